ifetch_sram_bridge: RTL and testbench

- Instruction-side bus bridge sitting directly upstream of the fetch stage.
- Takes the PC held by the fetch register and issues a single-beat SRAM-like read on the instruction port.
- Returns the fetched word as the fetch stage's instr_ input, and drives i_data_ok to hazard control so stallF can be raised while a fetch is outstanding.
- Handles pipeline redirects (flush) by discarding in-flight responses, and flags misaligned PCs without touching the bus.

---
 rtl/ifetch_sram_bridge.sv | 150 +++++++++++++++
 tb/tb_ifetch_sram_bridge.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_sram_bridge.sv
// Instruction-side bridge: turns the fetch-stage PC into a single-beat SRAM-like read
// and hands the returned word back to fetch, tolerating redirects and misaligned PCs.
module ifetch_sram_bridge #(
  parameter bit          KSEG_MAP = 1'b1,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc,
  input  logic        pc_req,
  input  logic        stall,
  input  logic        flush,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instr,
  output logic        i_data_ok,
  output logic        addr_err
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_DROP = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic              kill_q, kill_d;
  logic              inst_req_q, inst_req_d;
  logic [XLEN-1:0]   inst_addr_q, inst_addr_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              i_data_ok_q, i_data_ok_d;
  logic              addr_err_q, addr_err_d;
  logic              misaligned_c;
  logic              killed_c;

  // kseg0/kseg1 fold onto the low 512 MiB of physical space
  function automatic logic [XLEN-1:0] map_addr(input logic [XLEN-1:0] va);
    if (KSEG_MAP && (va[31:30] == 2'b10)) begin
      return {3'b000, va[28:0]};
    end
    return va;
  endfunction

  assign misaligned_c = (pc[1:0] != 2'b00);
  assign killed_c     = kill_q | flush;

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      inst_req_q  <= 1'b0;
      inst_addr_q <= '0;
      instr_q     <= NOP_WORD;
      i_data_ok_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_q      <= kill_d;
      inst_req_q  <= inst_req_d;
      inst_addr_q <= inst_addr_d;
      instr_q     <= instr_d;
      i_data_ok_q <= i_data_ok_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Next state; a flush during REQ is remembered because the request cannot be withdrawn
  always_comb begin
    state_d = state_q;
    kill_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pc_req && !flush) begin
          state_d = misaligned_c ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        kill_d = killed_c;
        if (inst_addr_ok) begin
          kill_d = 1'b0;
          if (killed_c) begin
            state_d = inst_data_ok ? S_IDLE : S_DROP;
          end else begin
            state_d = inst_data_ok ? S_DONE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          state_d = flush ? S_IDLE : S_DONE;
        end else if (flush) begin
          state_d = S_DROP;
        end
      end
      S_DONE: begin
        if (flush || !stall) begin
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        if (inst_data_ok) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values derived from the transition being taken
  always_comb begin
    inst_req_d  = (state_d == S_REQ);
    i_data_ok_d = (state_d == S_DONE);
    inst_addr_d = inst_addr_q;
    instr_d     = instr_q;
    addr_err_d  = addr_err_q;
    if (state_q == S_IDLE && state_d == S_REQ) begin
      inst_addr_d = map_addr(pc);
      addr_err_d  = 1'b0;
    end
    if (state_q == S_IDLE && state_d == S_DONE) begin
      instr_d    = NOP_WORD;
      addr_err_d = 1'b1;
    end
    if ((state_q == S_REQ || state_q == S_WAIT) && state_d == S_DONE) begin
      instr_d    = inst_rdata;
      addr_err_d = 1'b0;
    end
  end

  assign inst_req   = inst_req_q;
  assign inst_wr    = 1'b0;
  assign inst_size  = 2'b10;
  assign inst_addr  = inst_addr_q;
  assign inst_wdata = '0;
  assign instr      = instr_q;
  assign i_data_ok  = i_data_ok_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_ifetch_sram_bridge.sv
// Bench for ifetch_sram_bridge: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a transaction-level model.
module tb_ifetch_sram_bridge;

  logic        clk;
  logic        resetn;
  logic [31:0] pc;
  logic        pc_req, stall, flush;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic        i_data_ok, addr_err;

  int checks = 0;
  int errors = 0;

  ifetch_sram_bridge dut (
    .clk          (clk),
    .resetn       (resetn),
    .pc           (pc),
    .pc_req       (pc_req),
    .stall        (stall),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (addr_ok),
    .inst_data_ok (data_ok),
    .inst_rdata   (rdata),
    .instr        (instr),
    .i_data_ok    (i_data_ok),
    .addr_err     (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction view: a request on the bus, an accepted read awaiting data, a kill
  // mark for a redirected fetch, and the instruction currently handed to fetch.
  typedef struct packed {
    logic        req;
    logic        pend;
    logic        kill;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } model_t;

  model_t m;

  function automatic logic [31:0] phys(input logic [31:0] va);
    return (va[31:30] == 2'b10) ? (va & 32'h1FFF_FFFF) : va;
  endfunction

  function automatic model_t model_next(input model_t cur);
    model_t n;
    logic   dead;
    n    = cur;
    dead = cur.kill | flush;
    if (cur.valid) begin
      if (flush || !stall) n.valid = 1'b0;
    end else if (cur.req) begin
      if (addr_ok) begin
        n.req  = 1'b0;
        n.kill = 1'b0;
        if (data_ok) begin
          if (!dead) begin
            n.valid = 1'b1; n.instr = rdata; n.err = 1'b0;
          end
        end else begin
          n.pend = 1'b1;
          n.kill = dead;
        end
      end else begin
        n.kill = dead;
      end
    end else if (cur.pend) begin
      if (data_ok) begin
        n.pend = 1'b0;
        n.kill = 1'b0;
        if (!dead) begin
          n.valid = 1'b1; n.instr = rdata; n.err = 1'b0;
        end
      end else begin
        n.kill = dead;
      end
    end else if (pc_req && !flush) begin
      if (pc[1:0] != 2'b00) begin
        n.valid = 1'b1; n.instr = 32'h0; n.err = 1'b1;
      end else begin
        n.req = 1'b1; n.addr = phys(pc); n.err = 1'b0; n.kill = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m <= '0;
    else         m <= model_next(m);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%08h exp=%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cmp_inst_req",   32'(inst_req),  32'(m.req));
    chk("cmp_inst_addr",  inst_addr,      m.addr);
    chk("cmp_i_data_ok",  32'(i_data_ok), 32'(m.valid));
    chk("cmp_instr",      instr,          m.instr);
    chk("cmp_bus_const",  {inst_wdata[29:0], inst_wr, inst_size[0]} , 32'h0);
    chk("cmp_inst_size",  32'(inst_size), 32'h2);
    if (m.valid) chk("cmp_addr_err", 32'(addr_err), 32'(m.err));
  end

  initial begin
    resetn = 1'b0; pc = '0; pc_req = 1'b0; stall = 1'b0; flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(inst_req), 32'h0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ok", 32'(i_data_ok), 32'h0);
    chk("rst_err", 32'(addr_err), 32'h0);
    resetn = 1'b1;

    // zero-wait fetch from the boot vector
    @(negedge clk); pc = 32'hBFC0_0000; pc_req = 1'b1;
    @(negedge clk);
    chk("t1_req", 32'(inst_req), 32'h1);
    chk("t1_addr", inst_addr, 32'h1FC0_0000);
    chk("t1_ok_early", 32'(i_data_ok), 32'h0);
    pc_req = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h3C08_BFAF;
    @(negedge clk);
    chk("t1_req_low", 32'(inst_req), 32'h0);
    chk("t1_ok", 32'(i_data_ok), 32'h1);
    chk("t1_instr", instr, 32'h3C08_BFAF);
    chk("t1_err", 32'(addr_err), 32'h0);
    addr_ok = 1'b0; data_ok = 1'b0;
    @(negedge clk);
    chk("t1_ok_clear", 32'(i_data_ok), 32'h0);

    // addr_ok after 3 waits, data 2 cycles later
    pc = 32'h0040_0000; pc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_req_hold", 32'(inst_req), 32'h1);
      chk("t2_addr_hold", inst_addr, 32'h0040_0000);
      pc_req = 1'b0; addr_ok = (i == 3);
    end
    @(negedge clk);
    chk("t2_req_low", 32'(inst_req), 32'h0);
    chk("t2_ok_wait", 32'(i_data_ok), 32'h0);
    addr_ok = 1'b0;
    @(negedge clk);
    chk("t2_ok_wait2", 32'(i_data_ok), 32'h0);
    data_ok = 1'b1; rdata = 32'h2408_0001;
    @(negedge clk);
    chk("t2_ok", 32'(i_data_ok), 32'h1);
    chk("t2_instr", instr, 32'h2408_0001);
    data_ok = 1'b0;
    @(negedge clk);

    // flush while waiting for data
    pc = 32'h0000_1000; pc_req = 1'b1;
    @(negedge clk); pc_req = 1'b0; addr_ok = 1'b1;
    @(negedge clk); chk("t3_req_low", 32'(inst_req), 32'h0); addr_ok = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    @(negedge clk); data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t3_ok_dropped", 32'(i_data_ok), 32'h0);
    chk("t3_instr_kept", instr, 32'h2408_0001);
    data_ok = 1'b0; pc = 32'h8000_0100; pc_req = 1'b1;
    @(negedge clk);
    chk("t3_req2", 32'(inst_req), 32'h1);
    chk("t3_addr2", inst_addr, 32'h0000_0100);
    pc_req = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h8C09_0004;
    @(negedge clk);
    chk("t3_ok2", 32'(i_data_ok), 32'h1);
    chk("t3_instr2", instr, 32'h8C09_0004);
    addr_ok = 1'b0; data_ok = 1'b0;
    @(negedge clk);

    // flush before address acceptance
    pc = 32'h0000_2000; pc_req = 1'b1;
    @(negedge clk); pc_req = 1'b0; flush = 1'b1;
    @(negedge clk); chk("t4_req_held", 32'(inst_req), 32'h1); flush = 1'b0;
    @(negedge clk); chk("t4_req_held2", 32'(inst_req), 32'h1); addr_ok = 1'b1;
    @(negedge clk); chk("t4_req_low", 32'(inst_req), 32'h0);
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_1111;
    @(negedge clk);
    chk("t4_ok_dropped", 32'(i_data_ok), 32'h0);
    chk("t4_instr_kept", instr, 32'h8C09_0004);
    data_ok = 1'b0; pc = 32'h0000_2004; pc_req = 1'b1;
    @(negedge clk);
    chk("t4_restart", 32'(inst_req), 32'h1);
    chk("t4_restart_addr", inst_addr, 32'h0000_2004);
    pc_req = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h0109_5020;
    @(negedge clk);
    chk("t4_ok", 32'(i_data_ok), 32'h1);
    addr_ok = 1'b0; data_ok = 1'b0;
    @(negedge clk);

    // misaligned pc never reaches the bus
    pc = 32'hBFC0_0002; pc_req = 1'b1;
    @(negedge clk);
    chk("t5_no_req", 32'(inst_req), 32'h0);
    chk("t5_ok", 32'(i_data_ok), 32'h1);
    chk("t5_err", 32'(addr_err), 32'h1);
    chk("t5_nop", instr, 32'h0);
    pc_req = 1'b0;
    @(negedge clk);
    chk("t5_ok_clear", 32'(i_data_ok), 32'h0);
    chk("t5_no_req2", 32'(inst_req), 32'h0);

    // decode stall holds the delivered word
    stall = 1'b1; pc = 32'h0000_3000; pc_req = 1'b1;
    @(negedge clk); pc_req = 1'b0; addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'hAC0A_0008;
    @(negedge clk); addr_ok = 1'b0; data_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("t6_ok_held", 32'(i_data_ok), 32'h1);
      chk("t6_instr_held", instr, 32'hAC0A_0008);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("t6_release", 32'(i_data_ok), 32'h0);

    // reset in the middle of a read, then a stale response
    pc = 32'h0000_4000; pc_req = 1'b1;
    @(negedge clk); pc_req = 1'b0; addr_ok = 1'b1;
    @(negedge clk); addr_ok = 1'b0;
    @(negedge clk); resetn = 1'b0;
    #1;
    chk("t7_rst_req", 32'(inst_req), 32'h0);
    chk("t7_rst_addr", inst_addr, 32'h0);
    chk("t7_rst_instr", instr, 32'h0);
    chk("t7_rst_ok", 32'(i_data_ok), 32'h0);
    chk("t7_rst_err", 32'(addr_err), 32'h0);
    @(negedge clk); resetn = 1'b1; data_ok = 1'b1; rdata = 32'h5555_5555;
    @(negedge clk);
    chk("t7_late_ok", 32'(i_data_ok), 32'h0);
    chk("t7_late_instr", instr, 32'h0);
    chk("t7_late_req", 32'(inst_req), 32'h0);
    data_ok = 1'b0;

    // randomized traffic; the slave answers only what is actually outstanding
    repeat (3000) begin
      @(negedge clk);
      pc = $urandom;
      pc[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      pc_req  = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 9) == 0);
      stall   = ($urandom_range(0, 2) == 0);
      addr_ok = m.req && ($urandom_range(0, 2) == 0);
      data_ok = (addr_ok && ($urandom_range(0, 1) == 1)) ||
                (m.pend && ($urandom_range(0, 2) == 0));
      rdata   = $urandom;
    end
    @(negedge clk);
    pc_req = 1'b0; flush = 1'b0; stall = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
